ptp_up_cmd_seq: RTL and testbench
=================================

// Module: ptp_up_cmd_seq
// PURPOSE
//  Synthesizable bus-master sequencer for the ha1588 register interface (wr_in/rd_in/addr_in/data_in/data_out).
//  Accepts queued commands (WRITE, READ, POLL, WAIT) and executes them as single-cycle register strobes.
//  Returns read/poll results on a valid/ready response port.
//  Sits between a host or config engine and ha1588 for bring-up, RTC setup and TSU polling without software.
// PARAMETERS
//  AW          8    register address width
//  DW          32   register data width
//  DEPTH       4    command FIFO entries; power of two, >=2
//  RD_LAT      1    cycles from rd strobe to valid up_data_rd; 1..4
//  POLL_GAP    4    idle cycles between successive POLL reads
//  POLL_MAX    16   max reads per POLL before timeout; >=1
// PORTS
//  clk          in   1     single clock; same domain as ha1588 clk
//  rst_n        in   1     asynchronous active-low reset
//  cmd_valid    in   1     command offered
//  cmd_ready    out  1     FIFO not full
//  cmd_op       in   2     00 WRITE, 01 READ, 10 POLL, 11 WAIT
//  cmd_addr     in   AW    register address
//  cmd_data     in   DW    write data / POLL expected value / WAIT count in [15:0]
//  cmd_mask     in   DW    POLL compare mask
//  up_wr        out  1     write strobe, one cycle
//  up_rd        out  1     read strobe, one cycle
//  up_addr      out  AW    register address
//  up_data_wr   out  DW    write data
//  up_data_rd   in   DW    read data from ha1588
//  rsp_valid    out  1     response held until rsp_ready
//  rsp_ready    in   1     response accepted
//  rsp_data     out  DW    read value (POLL: last value read)
//  rsp_timeout  out  1     POLL exhausted POLL_MAX reads without match
//  busy         out  1     FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; FIFO emptied; FSM IDLE. Reset mid-command aborts with no further strobes.
//  FIFO: push on cmd_valid&&cmd_ready. Pop only in IDLE. Simultaneous push+pop when full is not possible (ready=0).
//    Full: cmd_ready=0.
//  FSM states: IDLE, WR, RD, RD_WAIT, CHECK, GAP, DLY, RSP.
//  IDLE: FIFO non-empty -> pop head, register addr/data/mask/op.
//    Goto WR / RD / RD (poll count=1) / DLY.
//  WR: up_wr=1, up_addr, up_data_wr valid for exactly 1 cycle -> IDLE. No response generated.
//  RD: up_rd=1 for 1 cycle with up_addr. RD_WAIT counts RD_LAT-1 further cycles.
//    up_data_rd is sampled RD_LAT cycles after the up_rd cycle.
//  READ: after sampling -> RSP with rsp_timeout=0.
//  POLL: after sampling -> CHECK. match = ((rd ^ cmd_data) & cmd_mask)==0.
//    match -> RSP, timeout=0.
//    no match and count==POLL_MAX -> RSP, timeout=1.
//    else GAP for POLL_GAP cycles, count++ -> RD.
//  WAIT: DLY counts cmd_data[15:0] cycles -> IDLE. Count 0 returns to IDLE next cycle. No response generated.
//  RSP: rsp_valid=1, rsp_data/rsp_timeout stable until rsp_ready. Exit to IDLE in the same cycle as the handshake.
//    No new strobe is issued while in RSP; ordering is strict FIFO.
//  up_wr and up_rd are never high together. At least 1 idle cycle separates consecutive strobes (IDLE pass).
//  up_addr/up_data_wr hold their last values outside strobes; they are don't-care to the slave.
//  Latency from cmd accept (empty FIFO) to first strobe: 2 cycles (FIFO write, IDLE pop).
//  Counters: poll count ceil(log2(POLL_MAX+1)) bits; delay 16 bits; RD_LAT counter 2 bits.
// STRUCTURE
//  Shared package ptp_pkg: op codes OP_WRITE/OP_READ/OP_POLL/OP_WAIT and FSM state encodings.
//  Sub-module ptp_cmd_fifo: sync FIFO, DEPTH x (2+AW+2*DW), async active-low reset, full/empty flags.
//  Remainder: FSM, counters and output registers in this file. All outputs registered.
// TESTING
//  1 WRITE addr 0x00 data 0x8000_0000 -> one up_wr pulse with addr 0x00, data 0x8000_0000; no rsp_valid.
//  2 READ addr 0x10, slave returns 0x1234_5678, RD_LAT=1 and 3 -> rsp_data 0x1234_5678, timeout 0, one up_rd pulse.
//  3 POLL addr 0x00 mask 0x1 expect 0x1, slave returns 0,0,1 ->
//    3 up_rd pulses spaced by POLL_GAP+ idle cycles, rsp_data=1, timeout=0.
//  4 POLL never matching, POLL_MAX=16 -> exactly 16 up_rd pulses, rsp_timeout=1.
//  5 Push 5 commands with DEPTH=4 and rsp_ready held 0 ->
//    cmd_ready drops at 4 entries; no strobes after the first READ until rsp_ready=1; order preserved.
//  6 rst_n asserted during WAIT 1000 -> outputs 0, busy=0 immediately; no strobe after release until a new cmd.

Source files
------------

// File: rtl/ptp_pkg.sv
// Shared op codes, FSM state encodings and counter widths for the ha1588 command sequencer.
package ptp_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_WAIT  = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_CHECK,
        ST_GAP,
        ST_DLY,
        ST_RSP
    } state_e;

    localparam int DLY_W = 16;
    localparam int LAT_W = 2;

endpackage

// File: rtl/ptp_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO with registered full/empty flags.
module ptp_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nxt;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign count_nxt = count + CW'(do_push) - CW'(do_pop);
    assign rdata     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/ptp_up_cmd_seq.sv
// Bus-master sequencer: replays queued WRITE/READ/POLL/WAIT commands as ha1588 register strobes.
module ptp_up_cmd_seq
    import ptp_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int DEPTH    = 4,
    parameter int RD_LAT   = 1,
    parameter int POLL_GAP = 4,
    parameter int POLL_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    input  logic [DW-1:0] cmd_mask,
    output logic          up_wr,
    output logic          up_rd,
    output logic [AW-1:0] up_addr,
    output logic [DW-1:0] up_data_wr,
    input  logic [DW-1:0] up_data_rd,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_timeout,
    output logic          busy
);
    localparam int EW       = 2 + AW + 2 * DW;
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int PCW      = $clog2(POLL_MAX + 1);
    localparam int GAP_LOAD = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

    function automatic logic poll_match(input logic [DW-1:0] rd,
                                        input logic [DW-1:0] exp_val,
                                        input logic [DW-1:0] mask);
        return ((rd ^ exp_val) & mask) == '0;
    endfunction

    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] fifo_count_nxt;
    logic [EW-1:0] fifo_wdata;
    logic [EW-1:0] fifo_rdata;
    logic [1:0]    head_op;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic [DW-1:0] head_mask;

    state_e           state, state_nxt;
    cmd_op_e          op, op_nxt;
    logic [DW-1:0]    exp_val, exp_val_nxt;
    logic [DW-1:0]    mask_val, mask_val_nxt;
    logic [DW-1:0]    rd_val, rd_val_nxt;
    logic [PCW-1:0]   poll_cnt, poll_cnt_nxt;
    logic [DLY_W-1:0] dly_cnt, dly_cnt_nxt;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_nxt;
    logic             up_wr_nxt;
    logic             up_rd_nxt;
    logic [AW-1:0]    up_addr_nxt;
    logic [DW-1:0]    up_data_wr_nxt;
    logic             rsp_valid_nxt;
    logic [DW-1:0]    rsp_data_nxt;
    logic             rsp_timeout_nxt;
    logic             busy_nxt;

    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign fifo_wdata = {cmd_op, cmd_addr, cmd_data, cmd_mask};
    assign head_op    = fifo_rdata[EW-1 -: 2];
    assign head_addr  = fifo_rdata[2*DW +: AW];
    assign head_data  = fifo_rdata[DW +: DW];
    assign head_mask  = fifo_rdata[0 +: DW];

    assign fifo_count_nxt = fifo_count + CW'(push) - CW'(pop);

    ptp_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt       = state;
        op_nxt          = op;
        exp_val_nxt     = exp_val;
        mask_val_nxt    = mask_val;
        rd_val_nxt      = rd_val;
        poll_cnt_nxt    = poll_cnt;
        dly_cnt_nxt     = dly_cnt;
        lat_cnt_nxt     = lat_cnt;
        up_wr_nxt       = 1'b0;
        up_rd_nxt       = 1'b0;
        up_addr_nxt     = up_addr;
        up_data_wr_nxt  = up_data_wr;
        rsp_valid_nxt   = rsp_valid;
        rsp_data_nxt    = rsp_data;
        rsp_timeout_nxt = rsp_timeout;
        pop             = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    op_nxt       = cmd_op_e'(head_op);
                    exp_val_nxt  = head_data;
                    mask_val_nxt = head_mask;
                    case (cmd_op_e'(head_op))
                        OP_WRITE: begin
                            state_nxt      = ST_WR;
                            up_wr_nxt      = 1'b1;
                            up_addr_nxt    = head_addr;
                            up_data_wr_nxt = head_data;
                        end
                        OP_READ, OP_POLL: begin
                            state_nxt    = ST_RD;
                            up_rd_nxt    = 1'b1;
                            up_addr_nxt  = head_addr;
                            poll_cnt_nxt = PCW'(1);
                        end
                        default: begin
                            state_nxt   = ST_DLY;
                            dly_cnt_nxt = head_data[DLY_W-1:0];
                        end
                    endcase
                end
            end
            ST_WR: state_nxt = ST_IDLE;
            ST_RD: begin
                state_nxt   = ST_RD_WAIT;
                lat_cnt_nxt = LAT_W'(RD_LAT - 1);
            end
            ST_RD_WAIT: begin
                if (lat_cnt == '0) begin
                    if (op == OP_POLL) begin
                        state_nxt  = ST_CHECK;
                        rd_val_nxt = up_data_rd;
                    end else begin
                        state_nxt       = ST_RSP;
                        rsp_valid_nxt   = 1'b1;
                        rsp_data_nxt    = up_data_rd;
                        rsp_timeout_nxt = 1'b0;
                    end
                end else begin
                    lat_cnt_nxt = lat_cnt - LAT_W'(1);
                end
            end
            ST_CHECK: begin
                // A match wins over exhaustion on the final read.
                if (poll_match(rd_val, exp_val, mask_val) || poll_cnt == PCW'(POLL_MAX)) begin
                    state_nxt       = ST_RSP;
                    rsp_valid_nxt   = 1'b1;
                    rsp_data_nxt    = rd_val;
                    rsp_timeout_nxt = !poll_match(rd_val, exp_val, mask_val);
                end else if (POLL_GAP == 0) begin
                    state_nxt    = ST_RD;
                    up_rd_nxt    = 1'b1;
                    poll_cnt_nxt = poll_cnt + PCW'(1);
                end else begin
                    state_nxt   = ST_GAP;
                    dly_cnt_nxt = DLY_W'(GAP_LOAD);
                end
            end
            ST_GAP: begin
                if (dly_cnt == '0) begin
                    state_nxt    = ST_RD;
                    up_rd_nxt    = 1'b1;
                    poll_cnt_nxt = poll_cnt + PCW'(1);
                end else begin
                    dly_cnt_nxt = dly_cnt - DLY_W'(1);
                end
            end
            ST_DLY: begin
                if (dly_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    dly_cnt_nxt = dly_cnt - DLY_W'(1);
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_nxt     = ST_IDLE;
                    rsp_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt != ST_IDLE) || (fifo_count_nxt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op          <= OP_WRITE;
            poll_cnt    <= '0;
            dly_cnt     <= '0;
            lat_cnt     <= '0;
            up_wr       <= 1'b0;
            up_rd       <= 1'b0;
            up_addr     <= '0;
            up_data_wr  <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            op          <= op_nxt;
            poll_cnt    <= poll_cnt_nxt;
            dly_cnt     <= dly_cnt_nxt;
            lat_cnt     <= lat_cnt_nxt;
            up_wr       <= up_wr_nxt;
            up_rd       <= up_rd_nxt;
            up_addr     <= up_addr_nxt;
            up_data_wr  <= up_data_wr_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_data    <= rsp_data_nxt;
            rsp_timeout <= rsp_timeout_nxt;
            busy        <= busy_nxt;
        end
    end

    // Command operands are only consulted after the FSM has loaded them.
    always_ff @(posedge clk) begin
        exp_val  <= exp_val_nxt;
        mask_val <= mask_val_nxt;
        rd_val   <= rd_val_nxt;
    end

endmodule

// File: tb/tb_ptp_up_cmd_seq.sv
// Directed bench for ptp_up_cmd_seq: one instance at RD_LAT=1 for all scenarios, one at RD_LAT=3 for READ.
module tb_ptp_up_cmd_seq;
    import ptp_pkg::*;

    localparam int AW       = 8;
    localparam int DW       = 32;
    localparam int POLL_GAP = 4;
    localparam int POLL_MAX = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data, cmd_mask;
    logic          up_wr, up_rd;
    logic [AW-1:0] up_addr;
    logic [DW-1:0] up_data_wr, up_data_rd;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_timeout, busy;

    logic          b_cmd_valid, b_cmd_ready;
    logic [1:0]    b_cmd_op;
    logic [AW-1:0] b_cmd_addr;
    logic [DW-1:0] b_cmd_data, b_cmd_mask;
    logic          b_up_wr, b_up_rd;
    logic [AW-1:0] b_up_addr;
    logic [DW-1:0] b_up_data_wr, b_up_data_rd;
    logic          b_rsp_valid, b_rsp_ready;
    logic [DW-1:0] b_rsp_data;
    logic          b_rsp_timeout, b_busy;

    ptp_up_cmd_seq #(.AW(AW), .DW(DW), .DEPTH(4), .RD_LAT(1), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .up_wr(up_wr), .up_rd(up_rd), .up_addr(up_addr), .up_data_wr(up_data_wr), .up_data_rd(up_data_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .busy(busy)
    );

    ptp_up_cmd_seq #(.AW(AW), .DW(DW), .DEPTH(4), .RD_LAT(3), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)) u_dut_lat3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op), .cmd_addr(b_cmd_addr),
        .cmd_data(b_cmd_data), .cmd_mask(b_cmd_mask),
        .up_wr(b_up_wr), .up_rd(b_up_rd), .up_addr(b_up_addr), .up_data_wr(b_up_data_wr),
        .up_data_rd(b_up_data_rd),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_timeout(b_rsp_timeout),
        .busy(b_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp_v);
        end
    endtask

    // Slave models: read data is only valid exactly RD_LAT cycles after the strobe, garbage otherwise.
    logic [DW-1:0] slave_vals [64];
    logic [DW-1:0] rd_val = '0;
    logic          rd_pipe = 1'b0;
    int            rd_n = 0;
    logic [2:0]    rd3_pipe = '0;
    assign up_data_rd   = rd_pipe ? rd_val : 32'hDEAD_BEEF;
    assign b_up_data_rd = rd3_pipe[2] ? 32'h1234_5678 : 32'hDEAD_BEEF;

    int            cyc = 0;
    int            ev_n = 0;
    bit            ev_rd [256];
    logic [AW-1:0] ev_addr [256];
    int            ev_cyc [256];
    int            rsp_n = 0;
    logic [DW-1:0] rsp_log [64];
    logic          rsp_to_log [64];
    bit            both_seen = 1'b0;
    bit            b2b_seen = 1'b0;
    logic          prev_strobe = 1'b0;
    int            rd3_n = 0;
    int            rsp3_n = 0;
    logic [DW-1:0] rsp3_data = '0;
    logic          rsp3_to = 1'b0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        prev_strobe <= up_wr | up_rd;
        rd_pipe     <= up_rd;
        if (up_wr && up_rd) both_seen <= 1'b1;
        if ((up_wr || up_rd) && prev_strobe) b2b_seen <= 1'b1;
        if ((up_wr || up_rd) && ev_n < 256) begin
            ev_rd[ev_n]   <= up_rd;
            ev_addr[ev_n] <= up_addr;
            ev_cyc[ev_n]  <= cyc;
            ev_n          <= ev_n + 1;
        end
        if (up_rd) begin
            rd_val <= (rd_n < 64) ? slave_vals[rd_n[5:0]] : 32'hFFFF_FFFE;
            rd_n   <= rd_n + 1;
        end
        if (rsp_valid && rsp_ready && rsp_n < 64) begin
            rsp_log[rsp_n]    <= rsp_data;
            rsp_to_log[rsp_n] <= rsp_timeout;
            rsp_n             <= rsp_n + 1;
        end
        rd3_pipe <= {rd3_pipe[1:0], b_up_rd};
        if (b_up_rd) rd3_n <= rd3_n + 1;
        if (b_rsp_valid && b_rsp_ready) begin
            rsp3_data <= b_rsp_data;
            rsp3_to   <= b_rsp_timeout;
            rsp3_n    <= rsp3_n + 1;
        end
    end

    function automatic int n_rd_from(input int from);
        int k = 0;
        for (int i = from; i < ev_n; i++) if (ev_rd[i]) k++;
        return k;
    endfunction

    function automatic int n_wr_from(input int from);
        int k = 0;
        for (int i = from; i < ev_n; i++) if (!ev_rd[i]) k++;
        return k;
    endfunction

    task automatic push(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        int g = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
        while (!cmd_ready && g < 200) begin
            @(posedge clk); #1; g++;
        end
        check("push_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int g = 0;
        while (rsp_n < target && g < 2000) begin
            @(posedge clk); #1; g++;
        end
        check(tag, rsp_n, target);
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while ((busy || rsp_valid) && g < 3000) begin
            @(posedge clk); #1; g++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, r0, mg, g;
        for (int i = 0; i < 64; i++) slave_vals[i] = 32'hFFFF_FFFE;
        cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; cmd_mask = 0; rsp_ready = 1;
        b_cmd_valid = 0; b_cmd_op = 0; b_cmd_addr = 0; b_cmd_data = 0; b_cmd_mask = 0; b_rsp_ready = 1;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_up_wr", up_wr, 0);
        check("rst_up_rd", up_rd, 0);
        check("rst_rsp_valid", rsp_valid, 0);

        // WRITE: strobe appears on the second edge after acceptance and lasts one cycle
        base = ev_n; r0 = rsp_n;
        push(OP_WRITE, 8'h00, 32'h8000_0000, 32'h0);
        check("wr_not_early", up_wr, 0);
        @(posedge clk); #1;
        check("wr_strobe", up_wr, 1);
        check("wr_addr", up_addr, 32'h00);
        check("wr_data", up_data_wr, 32'h8000_0000);
        @(posedge clk); #1;
        check("wr_one_cycle", up_wr, 0);
        wait_idle("wr_idle");
        check("wr_count", n_wr_from(base), 1);
        check("wr_no_rsp", rsp_n, r0);

        // READ at RD_LAT=1
        base = ev_n; r0 = rsp_n;
        slave_vals[rd_n] = 32'h1234_5678;
        push(OP_READ, 8'h10, 32'h0, 32'h0);
        wait_rsp(r0 + 1, "rd_rsp_seen");
        check("rd_data", rsp_log[r0], 32'h1234_5678);
        check("rd_timeout", rsp_to_log[r0], 0);
        wait_idle("rd_idle");
        check("rd_count", n_rd_from(base), 1);
        check("rd_addr", ev_addr[base], 32'h10);

        // READ at RD_LAT=3
        b_cmd_valid = 1; b_cmd_op = OP_READ; b_cmd_addr = 8'h10;
        @(posedge clk); #1;
        b_cmd_valid = 0;
        g = 0;
        while (rsp3_n < 1 && g < 200) begin
            @(posedge clk); #1; g++;
        end
        check("rd3_rsp_seen", rsp3_n, 1);
        check("rd3_data", rsp3_data, 32'h1234_5678);
        check("rd3_timeout", rsp3_to, 0);
        check("rd3_count", rd3_n, 1);

        // POLL matching on the third read
        base = ev_n; r0 = rsp_n;
        slave_vals[rd_n] = 32'h0; slave_vals[rd_n + 1] = 32'h0; slave_vals[rd_n + 2] = 32'h1;
        push(OP_POLL, 8'h00, 32'h1, 32'h1);
        wait_rsp(r0 + 1, "poll_rsp_seen");
        check("poll_data", rsp_log[r0], 32'h1);
        check("poll_timeout", rsp_to_log[r0], 0);
        wait_idle("poll_idle");
        check("poll_reads", n_rd_from(base), 3);
        mg = 1000;
        for (int i = base + 1; i < ev_n; i++)
            if (ev_cyc[i] - ev_cyc[i-1] - 1 < mg) mg = ev_cyc[i] - ev_cyc[i-1] - 1;
        check("poll_gap_min", mg >= POLL_GAP, 1);

        // POLL where unmasked bits differ but masked nibble matches on first read
        base = ev_n; r0 = rsp_n;
        slave_vals[rd_n] = 32'hFFFF_FF5A;
        push(OP_POLL, 8'h08, 32'h0000_0050, 32'h0000_00F0);
        wait_rsp(r0 + 1, "pmask_rsp_seen");
        check("pmask_data", rsp_log[r0], 32'hFFFF_FF5A);
        check("pmask_timeout", rsp_to_log[r0], 0);
        wait_idle("pmask_idle");
        check("pmask_reads", n_rd_from(base), 1);

        // POLL never matching: slave default 0xFFFF_FFFE has bit0 clear
        base = ev_n; r0 = rsp_n;
        push(OP_POLL, 8'h04, 32'h1, 32'h1);
        wait_rsp(r0 + 1, "pto_rsp_seen");
        check("pto_timeout", rsp_to_log[r0], 1);
        check("pto_data", rsp_log[r0], 32'hFFFF_FFFE);
        wait_idle("pto_idle");
        check("pto_reads", n_rd_from(base), POLL_MAX);

        // Backpressure: five commands, response stalled
        base = ev_n; r0 = rsp_n;
        rsp_ready = 0;
        slave_vals[rd_n] = 32'hCAFE_0001; slave_vals[rd_n + 1] = 32'hCAFE_0002;
        push(OP_READ,  8'h20, 32'h0,  32'h0);
        push(OP_WRITE, 8'h30, 32'h11, 32'h0);
        push(OP_READ,  8'h40, 32'h0,  32'h0);
        push(OP_WRITE, 8'h31, 32'h22, 32'h0);
        push(OP_WAIT,  8'h00, 32'h0,  32'h0);
        check("bp_full", cmd_ready, 0);
        repeat (20) @(posedge clk);
        #1;
        check("bp_hold_reads", n_rd_from(base), 1);
        check("bp_hold_writes", n_wr_from(base), 0);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_rsp_data", rsp_data, 32'hCAFE_0001);
        check("bp_still_full", cmd_ready, 0);
        check("bp_busy", busy, 1);
        rsp_ready = 1;
        wait_rsp(r0 + 2, "bp_rsp_seen");
        wait_idle("bp_idle");
        check("bp_events", ev_n - base, 4);
        check("bp_ev1_kind", ev_rd[base + 1], 0);
        check("bp_ev1_addr", ev_addr[base + 1], 32'h30);
        check("bp_ev2_kind", ev_rd[base + 2], 1);
        check("bp_ev2_addr", ev_addr[base + 2], 32'h40);
        check("bp_ev3_addr", ev_addr[base + 3], 32'h31);
        check("bp_rsp0", rsp_log[r0], 32'hCAFE_0001);
        check("bp_rsp1", rsp_log[r0 + 1], 32'hCAFE_0002);

        // Reset in the middle of a long WAIT
        base = ev_n;
        push(OP_WAIT, 8'h00, 32'd1000, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("wait_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_up_addr", up_addr, 0);
        check("arst_up_data_wr", up_data_wr, 0);
        check("arst_rsp_data", rsp_data, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (50) @(posedge clk);
        #1;
        check("arst_no_strobe", ev_n - base, 0);
        check("arst_idle", busy, 0);
        push(OP_WRITE, 8'h3C, 32'h5A, 32'h0);
        wait_idle("arst_wr_idle");
        check("arst_wr_count", n_wr_from(base), 1);
        check("arst_wr_addr", ev_addr[base], 32'h3C);

        check("never_wr_and_rd", both_seen, 0);
        check("never_back_to_back", b2b_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
